// File: rtl/ex_mem_stage_pkg.sv
// Shared types for the execute-to-memory stage: data and address widths,
// the skid-buffer entry record and the buffer occupancy states.
package ex_mem_stage_pkg;

  localparam int D_SIZE        = 32;
  localparam int ADDR_LINE     = 8;
  localparam int RD_W_DEFAULT  = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } ems_state_t;

  // The destination register index is held beside this record rather than
  // inside it, so that RD_W can be overridden per instance.
  typedef struct packed {
    logic              valid;
    logic              is_load;
    logic              is_store;
    logic [D_SIZE-1:0] alu_result;
    logic [D_SIZE-1:0] store_data;
    logic              reg_write;
    logic              done;
    logic [D_SIZE-1:0] captured_data;
  } ex_mem_entry_t;

endpackage

// File: rtl/ex_mem_skid_buf.sv
// Two-entry skid buffer (head H, skid S) with its occupancy FSM.
// Only H is visible downstream; S refills H when H pops, keeping order.
// The upstream ready is a flop, so it never depends combinationally on
// the downstream ready.
module ex_mem_skid_buf
  import ex_mem_stage_pkg::*;
#(
  parameter int RD_W = RD_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  ex_mem_entry_t          in_entry,
  input  logic [RD_W-1:0]        in_rd,
  input  logic                   flush,
  input  logic                   out_ready,
  input  logic                   cap_en,
  input  logic [D_SIZE-1:0]      cap_data,
  output ex_mem_entry_t          head,
  output logic [RD_W-1:0]        head_rd,
  output logic                   pop
);

  ems_state_t      state, state_nxt;
  ex_mem_entry_t   h, h_nxt, s, s_nxt;
  logic [RD_W-1:0] h_rd, h_rd_nxt, s_rd, s_rd_nxt;
  logic            rdy_q;
  logic            acc;

  assign acc      = in_valid & rdy_q;
  assign pop      = h.valid & out_ready;
  assign in_ready = rdy_q;
  assign head     = h;
  assign head_rd  = h_rd;

  // Next-state and entry movement; flush overrides everything else.
  always_comb begin
    state_nxt = state;
    h_nxt     = h;
    s_nxt     = s;
    h_rd_nxt  = h_rd;
    s_rd_nxt  = s_rd;

    if (cap_en) begin
      h_nxt.done          = 1'b1;
      h_nxt.captured_data = cap_data;
    end

    case (state)
      EMPTY: begin
        if (acc) begin
          h_nxt     = in_entry;
          h_rd_nxt  = in_rd;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (acc && !pop) begin
          s_nxt     = in_entry;
          s_rd_nxt  = in_rd;
          state_nxt = SKID;
        end else if (acc && pop) begin
          h_nxt     = in_entry;
          h_rd_nxt  = in_rd;
        end else if (pop) begin
          h_nxt     = '0;
          h_rd_nxt  = '0;
          state_nxt = EMPTY;
        end
      end
      SKID: begin
        if (pop) begin
          h_nxt      = s;
          h_nxt.done = 1'b0;
          h_rd_nxt   = s_rd;
          s_nxt      = '0;
          s_rd_nxt   = '0;
          state_nxt  = FULL;
        end
      end
      default: begin
        state_nxt = EMPTY;
        h_nxt     = '0;
        s_nxt     = '0;
        h_rd_nxt  = '0;
        s_rd_nxt  = '0;
      end
    endcase

    if (flush) begin
      state_nxt = EMPTY;
      h_nxt     = '0;
      s_nxt     = '0;
      h_rd_nxt  = '0;
      s_rd_nxt  = '0;
    end
  end

  // State, entry storage and the registered upstream ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      h     <= '0;
      s     <= '0;
      h_rd  <= '0;
      s_rd  <= '0;
      rdy_q <= 1'b1;
    end else begin
      state <= state_nxt;
      h     <= h_nxt;
      s     <= s_nxt;
      h_rd  <= h_rd_nxt;
      s_rd  <= s_rd_nxt;
      rdy_q <= (state_nxt != SKID);
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute-to-memory stage: buffers execute results in a two-entry skid
// buffer, drives the memory port from the head entry, captures load data
// and presents the writeback record.
// Optional build macro EX_MEM_STATS_EN adds saturating load/store/stall
// counters.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int RD_W = RD_W_DEFAULT
`ifdef EX_MEM_STATS_EN
  ,
  parameter int STAT_W = 32
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic                 ex_is_load,
  input  logic                 ex_is_store,
  input  logic [D_SIZE-1:0]    ex_alu_result,
  input  logic [D_SIZE-1:0]    ex_store_data,
  input  logic [RD_W-1:0]      ex_rd,
  input  logic                 ex_reg_write,
  input  logic                 flush,
  output logic                 rw,
  output logic [ADDR_LINE-1:0] addr_in,
  output logic [D_SIZE-1:0]    write_data,
  input  logic [D_SIZE-1:0]    read_data,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [D_SIZE-1:0]    wb_data,
  output logic [RD_W-1:0]      wb_rd,
  output logic                 wb_reg_write
`ifdef EX_MEM_STATS_EN
  ,
  output logic [STAT_W-1:0]    stat_loads,
  output logic [STAT_W-1:0]    stat_stores,
  output logic [STAT_W-1:0]    stat_stall_cycles
`endif
);

  ex_mem_entry_t   in_entry;
  ex_mem_entry_t   head;
  logic [RD_W-1:0] head_rd;
  logic            pop;
  logic            cap_en;

  // Pack the incoming op as a fresh, not-yet-accessed entry.
  always_comb begin
    in_entry            = '0;
    in_entry.valid      = 1'b1;
    in_entry.is_load    = ex_is_load;
    in_entry.is_store   = ex_is_store;
    in_entry.alu_result = ex_alu_result;
    in_entry.store_data = ex_store_data;
    in_entry.reg_write  = ex_reg_write;
  end

  // A held head marks itself done after its first memory cycle, which
  // both freezes load data and stops a stalled store from rewriting.
  assign cap_en = head.valid & ~pop & ~head.done;

  ex_mem_skid_buf #(
    .RD_W (RD_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (ex_valid),
    .in_ready  (ex_ready),
    .in_entry  (in_entry),
    .in_rd     (ex_rd),
    .flush     (flush),
    .out_ready (wb_ready),
    .cap_en    (cap_en),
    .cap_data  (read_data),
    .head      (head),
    .head_rd   (head_rd),
    .pop       (pop)
  );

  assign rw         = head.valid & head.is_store & ~head.done & ~flush;
  assign addr_in    = head.valid ? head.alu_result[ADDR_LINE-1:0] : '0;
  assign write_data = rw ? head.store_data : '0;

  assign wb_valid     = head.valid;
  assign wb_rd        = head_rd;
  assign wb_reg_write = head.reg_write & ~head.is_store;

  // Writeback data: frozen load data once captured, live data on the
  // first cycle, ALU result for everything else.
  always_comb begin
    wb_data = head.alu_result;
    if (head.is_load) begin
      wb_data = head.done ? head.captured_data : read_data;
    end
  end

`ifdef EX_MEM_STATS_EN
  // Saturating activity counters, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_loads        <= '0;
      stat_stores       <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (pop && head.is_load && (stat_loads != '1))
        stat_loads <= stat_loads + 1'b1;
      if (pop && head.is_store && (stat_stores != '1))
        stat_stores <= stat_stores + 1'b1;
      if (wb_valid && !wb_ready && (stat_stall_cycles != '1))
        stat_stall_cycles <= stat_stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage with a behavioural memory on the mem port.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ready, ex_is_load, ex_is_store;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, flush;
  logic        rw;
  logic [7:0]  addr_in;
  logic [31:0] write_data, read_data;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;

  logic        init_mem;
  logic [31:0] mem [256];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk           (clk),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_is_load    (ex_is_load),
    .ex_is_store   (ex_is_store),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .flush         (flush),
    .rw            (rw),
    .addr_in       (addr_in),
    .write_data    (write_data),
    .read_data     (read_data),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_data       (wb_data),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write)
  );

  // Memory model: combinational read, write on the clock edge when rw.
  assign read_data = mem[addr_in];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[2] <= 32'h55;
    end else if (rw) begin
      mem[addr_in] <= write_data;
    end
  end

  typedef struct {
    logic        ev, ld, st;
    logic [31:0] alu, sd;
    logic [4:0]  rd;
    logic        rgw, fl, wr;
    logic        x_rdy, x_wbv;
    logic [31:0] x_wbd;
    logic [4:0]  x_rd;
    logic        x_wbrw, x_rw;
    logic [7:0]  x_addr;
    logic [31:0] x_wd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic ev, ld, st, input logic [31:0] alu, sd,
                              input logic [4:0] rd, input logic rgw, fl, wr,
                              input logic xr, xv, input logic [31:0] xd,
                              input logic [4:0] xrd, input logic xrw, xm,
                              input logic [7:0] xa, input logic [31:0] xw);
    vec_t v;
    v.ev = ev; v.ld = ld; v.st = st; v.alu = alu; v.sd = sd; v.rd = rd;
    v.rgw = rgw; v.fl = fl; v.wr = wr;
    v.x_rdy = xr; v.x_wbv = xv; v.x_wbd = xd; v.x_rd = xrd;
    v.x_wbrw = xrw; v.x_rw = xm; v.x_addr = xa; v.x_wd = xw;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [80:0] got, exp;
    @(negedge clk);
    ex_valid = v.ev; ex_is_load = v.ld; ex_is_store = v.st;
    ex_alu_result = v.alu; ex_store_data = v.sd; ex_rd = v.rd;
    ex_reg_write = v.rgw; flush = v.fl; wb_ready = v.wr;
    #2;
    got = {ex_ready, wb_valid, wb_data, wb_rd, wb_reg_write, rw, addr_in, write_data};
    exp = {v.x_rdy, v.x_wbv, v.x_wbd, v.x_rd, v.x_wbrw, v.x_rw, v.x_addr, v.x_wd};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL vec%0d {rdy,wbv,wbd,rd,wbrw,rw,addr,wd}: got %h expected %h", idx, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; init_mem = 1'b1;
    ex_valid = 0; ex_is_load = 0; ex_is_store = 0; ex_alu_result = 0;
    ex_store_data = 0; ex_rd = 0; ex_reg_write = 0; flush = 0; wb_ready = 0;

    // Back-to-back store 7=0x11 then load 7
    tbl.push_back(mk(1,0,1, 7,'h11, 0,0,0,1,  1,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0, 7,0,    3,1,0,1,  1,1,7,0,0,1,7,'h11));
    tbl.push_back(mk(0,0,0, 0,0,    0,0,0,1,  1,1,'h11,3,1,0,7,0));
    tbl.push_back(mk(0,0,0, 0,0,    0,0,0,1,  1,0,0,0,0,0,0,0));
    // Store 3=0xA5 held five cycles, then load 3
    tbl.push_back(mk(1,0,1, 3,'hA5, 1,0,0,0,  1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,    0,0,0,0,  1,1,3,1,0,1,3,'hA5));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0,0,0, 0,0,  0,0,0,0,  1,1,3,1,0,0,3,0));
    tbl.push_back(mk(0,0,0, 0,0,    0,0,0,1,  1,1,3,1,0,0,3,0));
    tbl.push_back(mk(1,1,0, 3,0,    4,1,0,1,  1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,    0,0,0,1,  1,1,'hA5,4,1,0,3,0));
    // Load 2 stalled while store 2=0x66 waits in S
    tbl.push_back(mk(1,1,0, 2,0,    5,1,0,0,  1,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,1, 2,'h66, 0,0,0,0,  1,1,'h55,5,1,0,2,0));
    tbl.push_back(mk(0,0,0, 0,0,    0,0,0,0,  0,1,'h55,5,1,0,2,0));
    tbl.push_back(mk(0,0,0, 0,0,    0,0,0,0,  0,1,'h55,5,1,0,2,0));
    tbl.push_back(mk(0,0,0, 0,0,    0,0,0,1,  0,1,'h55,5,1,0,2,0));
    tbl.push_back(mk(0,0,0, 0,0,    0,0,0,0,  1,1,2,0,0,1,2,'h66));
    tbl.push_back(mk(0,0,0, 0,0,    0,0,0,1,  1,1,2,0,0,0,2,0));
    tbl.push_back(mk(1,1,0, 2,0,    6,1,0,1,  1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,    0,0,0,1,  1,1,'h66,6,1,0,2,0));
    // Three ALU ops against a stalled consumer
    tbl.push_back(mk(1,0,0, 'h101,0,1,1,0,0,  1,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0, 'h202,0,2,1,0,0,  1,1,'h101,1,1,0,1,0));
    tbl.push_back(mk(1,0,0, 'h303,0,3,1,0,0,  0,1,'h101,1,1,0,1,0));
    tbl.push_back(mk(1,0,0, 'h303,0,3,1,0,1,  0,1,'h101,1,1,0,1,0));
    tbl.push_back(mk(1,0,0, 'h303,0,3,1,0,1,  1,1,'h202,2,1,0,2,0));
    tbl.push_back(mk(0,0,0, 0,0,      0,0,0,1,  1,1,'h303,3,1,0,3,0));
    tbl.push_back(mk(0,0,0, 0,0,      0,0,0,1,  1,0,0,0,0,0,0,0));
    // Flush kills an uncommitted store and discards a same-cycle accept
    tbl.push_back(mk(1,0,1, 9,'hDEAD, 0,0,0,0,  1,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0, 9,0,      7,1,1,0,  1,1,9,0,0,0,9,0));
    tbl.push_back(mk(0,0,0, 0,0,      0,0,0,0,  1,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0, 9,0,      7,1,0,1,  1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,      0,0,0,1,  1,1,0,7,1,0,9,0));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    chk("reset_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("reset_rw_addr",  {23'd0, rw, addr_in}, 32'd0);
    chk("reset_wb_data",  wb_data, 32'd0);
    chk("reset_wb_rd_we", {26'd0, wb_rd, wb_reg_write}, 32'd0);
    @(negedge clk);
    reset = 1'b0; init_mem = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Reset asserted while two entries are held (load in H, store in S)
    @(negedge clk);
    ex_valid = 1; ex_is_load = 1; ex_is_store = 0; ex_alu_result = 32'h10;
    ex_rd = 2; ex_reg_write = 1; flush = 0; wb_ready = 0;
    @(negedge clk);
    ex_is_load = 0; ex_is_store = 1; ex_store_data = 32'h77; ex_reg_write = 0;
    @(negedge clk);
    ex_valid = 0;
    #2;
    chk("skid_pre_ready", {31'd0, ex_ready}, 32'd0);
    chk("skid_pre_valid", {31'd0, wb_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_mid_rw",       {31'd0, rw}, 32'd0);
    chk("rst_mid_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_mid_addr_wd",  {24'd0, addr_in} | write_data, 32'd0);
    chk("rst_mid_wb_data",  wb_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #2;
    chk("post_rst_ready", {30'd0, ex_ready, wb_valid}, 32'd2);
    chk("mem_0x10", mem[16], 32'd0);
    chk("mem_7",    mem[7],  32'h11);
    chk("mem_3",    mem[3],  32'hA5);
    chk("mem_2",    mem[2],  32'h66);
    chk("mem_9",    mem[9],  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
